sa_ctrl_4_4: RTL and testbench

SA_CTRL_4_4 -- requirements
Module: sa_ctrl_4_4

---
 rtl/sa_ctrl_4_4.sv | 206 ++++++++++++++++++++
 tb/tb_sa_ctrl_4_4.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_ctrl_4_4.sv
// sa_ctrl_4_4: sequencer for a 4x4 weight-stationary systolic array.
// Loads four weight rows from the top edge, then streams B columns into the
// left edge with a per-row skew. A valid tag follows each column through the
// array, and the bottom-edge outputs are captured and deskewed into one
// result column per accepted input column.
module sa_ctrl_4_4 #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_LAT  = 4
) (
  input  logic                    ctrl_clk,
  input  logic                    ctrl_rst_n,
  input  logic                    start,
  input  logic [3:0]              cfg_ncols,
  input  logic                    cfg_keep_w,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [4*DATA_WIDTH-1:0] w_data,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [4*DATA_WIDTH-1:0] a_data,
  output logic                    res_valid,
  output logic [4*DATA_WIDTH-1:0] res_data,
  output logic                    busy,
  output logic                    done,
  output logic                    array_mode,
  output logic [3:0]              array_en_up,
  output logic [4*DATA_WIDTH-1:0] array_data_up,
  output logic [3:0]              array_en_left,
  output logic [4*DATA_WIDTH-1:0] array_data_left,
  input  logic [4*DATA_WIDTH-1:0] array_data_down
);

  // Tag position k is high during the k-th cycle after a column's row-0 drive;
  // the last position feeds res_valid so it rises ARRAY_LAT+3 cycles after drive.
  localparam int TAG_LEN = ARRAY_LAT + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SWITCH,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           ncols_q, ncols_d;
  logic [1:0]           beat_cnt_q, beat_cnt_d;
  logic [3:0]           col_cnt_q, col_cnt_d;
  logic [TAG_LEN-1:0]   tag_q, tag_d;
  logic                 res_valid_q, res_valid_d;
  logic                 a_fire;

  // Next-state and handshake/array-edge outputs; everything defaults to idle values.
  always_comb begin
    state_d       = state_q;
    ncols_d       = ncols_q;
    beat_cnt_d    = beat_cnt_q;
    col_cnt_d     = col_cnt_q;
    w_ready       = 1'b0;
    a_ready       = 1'b0;
    a_fire        = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    array_mode    = 1'b0;
    array_en_up   = 4'h0;
    array_data_up = '0;
    array_en_left = 4'h0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        // A zero-column job has nothing to do, so it is not accepted at all.
        if (start && (cfg_ncols != 4'd0)) begin
          ncols_d    = cfg_ncols;
          beat_cnt_d = 2'd0;
          col_cnt_d  = 4'd0;
          state_d    = cfg_keep_w ? S_SWITCH : S_LOAD;
        end
      end
      S_LOAD: begin
        w_ready    = 1'b1;
        array_mode = 1'b1;
        if (w_valid) begin
          array_en_up   = 4'hF;
          array_data_up = w_data;
          beat_cnt_d    = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) begin
            state_d = S_SWITCH;
          end
        end
      end
      S_SWITCH: begin
        // One quiet cycle so the PEs see the mode change before any activation.
        state_d = S_STREAM;
      end
      S_STREAM: begin
        a_ready       = 1'b1;
        array_en_left = 4'hF;
        a_fire        = a_valid;
        if (a_valid) begin
          col_cnt_d = col_cnt_q + 4'd1;
          if ((col_cnt_q + 4'd1) == ncols_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        array_en_left = 4'hF;
        // With no tag left in flight, the result being presented is the last one.
        if ((tag_q == '0) && res_valid_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Column valid tag walks alongside the data through skew, array and deskew.
  always_comb begin
    tag_d       = {tag_q[TAG_LEN-2:0], a_fire};
    res_valid_d = tag_q[TAG_LEN-1];
  end

  // Control state registers.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state_q     <= S_IDLE;
      ncols_q     <= 4'd0;
      beat_cnt_q  <= 2'd0;
      col_cnt_q   <= 4'd0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ncols_q     <= ncols_d;
      beat_cnt_q  <= beat_cnt_d;
      col_cnt_q   <= col_cnt_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign res_valid = res_valid_q;

  // Input skew: row r passes through r+1 registers, so row r lags row 0 by r cycles.
  for (genvar gi = 0; gi < 4; gi++) begin : g_skew
    localparam int DEPTH = gi + 1;
    logic [DEPTH*DATA_WIDTH-1:0] sk_q, sk_d;
    logic [DATA_WIDTH-1:0]       sk_in;

    // Bubbles and drain cycles inject zeros.
    assign sk_in = a_fire ? a_data[DATA_WIDTH*gi +: DATA_WIDTH] : '0;

    if (DEPTH == 1) begin : g_one
      // Single stage: load the lane straight in.
      always_comb sk_d = sk_in;
    end else begin : g_chain
      // Shift the lane one stage deeper each cycle.
      always_comb sk_d = {sk_q[(DEPTH-1)*DATA_WIDTH-1:0], sk_in};
    end

    // Skew stage registers.
    always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
      if (!ctrl_rst_n) begin
        sk_q <= '0;
      end else begin
        sk_q <= sk_d;
      end
    end

    assign array_data_left[DATA_WIDTH*gi +: DATA_WIDTH] = sk_q[DEPTH*DATA_WIDTH-1 -: DATA_WIDTH];
  end

  // Output capture and deskew: lane c is captured when its tag copy says the
  // column has reached the bottom of column c, then held 3-c more cycles so
  // all four lanes line up with res_valid.
  for (genvar gi = 0; gi < 4; gi++) begin : g_deskew
    localparam int DEPTH = 4 - gi;
    logic [DEPTH*DATA_WIDTH-1:0] dk_q, dk_d;
    logic [DATA_WIDTH-1:0]       dk_in;

    assign dk_in = tag_q[ARRAY_LAT-1+gi] ? array_data_down[DATA_WIDTH*gi +: DATA_WIDTH] : '0;

    if (DEPTH == 1) begin : g_one
      // Rightmost column arrives last and needs only the capture stage.
      always_comb dk_d = dk_in;
    end else begin : g_chain
      // Capture stage followed by the remaining delay stages.
      always_comb dk_d = {dk_q[(DEPTH-1)*DATA_WIDTH-1:0], dk_in};
    end

    // Capture/deskew stage registers.
    always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
      if (!ctrl_rst_n) begin
        dk_q <= '0;
      end else begin
        dk_q <= dk_d;
      end
    end

    assign res_data[DATA_WIDTH*gi +: DATA_WIDTH] = dk_q[DEPTH*DATA_WIDTH-1 -: DATA_WIDTH];
  end

endmodule

// File: tb/tb_sa_ctrl_4_4.sv
// tb_sa_ctrl_4_4: directed bench for the systolic array sequencer, with a
// behavioural 4x4 weight-stationary array attached to the array edge ports.
module tb_sa_ctrl_4_4;

  localparam int DW  = 32;
  localparam int LAT = 4;
  localparam int BW  = 4 * DW;

  logic          ctrl_clk = 1'b0;
  logic          ctrl_rst_n;
  logic          start;
  logic [3:0]    cfg_ncols;
  logic          cfg_keep_w;
  logic          w_valid;
  logic          w_ready;
  logic [BW-1:0] w_data;
  logic          a_valid;
  logic          a_ready;
  logic [BW-1:0] a_data;
  logic          res_valid;
  logic [BW-1:0] res_data;
  logic          busy;
  logic          done;
  logic          array_mode;
  logic [3:0]    array_en_up;
  logic [BW-1:0] array_data_up;
  logic [3:0]    array_en_left;
  logic [BW-1:0] array_data_left;
  logic [BW-1:0] array_data_down;

  always #5 ctrl_clk = ~ctrl_clk;

  sa_ctrl_4_4 #(.DATA_WIDTH(DW), .ARRAY_LAT(LAT)) dut (
    .ctrl_clk        (ctrl_clk),
    .ctrl_rst_n      (ctrl_rst_n),
    .start           (start),
    .cfg_ncols       (cfg_ncols),
    .cfg_keep_w      (cfg_keep_w),
    .w_valid         (w_valid),
    .w_ready         (w_ready),
    .w_data          (w_data),
    .a_valid         (a_valid),
    .a_ready         (a_ready),
    .a_data          (a_data),
    .res_valid       (res_valid),
    .res_data        (res_data),
    .busy            (busy),
    .done            (done),
    .array_mode      (array_mode),
    .array_en_up     (array_en_up),
    .array_data_up   (array_data_up),
    .array_en_left   (array_en_left),
    .array_data_left (array_data_left),
    .array_data_down (array_data_down)
  );

  // ---------------- behavioural array ----------------
  // Weights shift down from the top on each enabled load beat; activations
  // move right and partial sums move down one PE per cycle. The bottom row's
  // sum is combinational, so column 0's result is sampled LAT edges after the
  // edge that drove row 0.
  logic [DW-1:0] pe_w [4][4];
  logic [DW-1:0] pe_a [4][4];
  logic [DW-1:0] pe_p [3][4];

  always @(posedge ctrl_clk) begin
    for (int c = 0; c < 4; c++) begin
      if (array_mode && array_en_up[c]) begin
        pe_w[0][c] <= array_data_up[DW*c +: DW];
        for (int r = 1; r < 4; r++) pe_w[r][c] <= pe_w[r-1][c];
      end
      for (int r = 0; r < 4; r++) begin
        logic [DW-1:0] ain;
        logic [DW-1:0] pin;
        ain = (c == 0) ? array_data_left[DW*r +: DW] : pe_a[r][(c > 0) ? c - 1 : 0];
        pin = (r == 0) ? '0 : pe_p[(r > 0) ? r - 1 : 0][c];
        pe_a[r][c] <= ain;
        if (r < 3) pe_p[(r < 3) ? r : 0][c] <= pin + pe_w[r][c] * ain;
      end
    end
  end

  always_comb begin
    array_data_down = '0;
    for (int c = 0; c < 4; c++) begin
      array_data_down[DW*c +: DW] = pe_p[2][c] + pe_w[3][c] *
        ((c == 0) ? array_data_left[3*DW +: DW] : pe_a[3][(c > 0) ? c - 1 : 0]);
    end
  end

  // ---------------- bookkeeping ----------------
  typedef struct {
    logic [BW-1:0] b_col;
    logic [BW-1:0] exp_res;
  } vec_t;

  typedef struct {
    logic [BW-1:0] data;
    bit            last;
  } exp_t;

  vec_t          vecs [3];
  logic [BW-1:0] beats [4];
  exp_t          exp_q [$];
  int            acc_q [$];
  int            cyc = 0;
  int            n_res = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  function automatic logic [BW-1:0] pack4(input int unsigned l0, input int unsigned l1,
                                          input int unsigned l2, input int unsigned l3);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sampled once per cycle at the falling edge: accepted columns and results.
  task automatic monitor();
    if (!ctrl_rst_n) begin
      acc_q.delete();
    end else if (a_valid && a_ready) begin
      acc_q.push_back(cyc);
    end
    if (res_valid) begin
      n_res++;
      $display("res %0d: data=%h done=%0b", n_res, res_data, done);
      if (exp_q.size() == 0) begin
        chk("unexpected_res_valid", res_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("done_with_res", done, e.last);
        // Accept is sampled in the cycle before the row-0 drive edge, hence LAT+4.
        if (acc_q.size() > 0) chk("res_latency", cyc - acc_q.pop_front(), LAT + 4);
        else chk("res_has_accept", acc_q.size(), 1);
      end
    end else if (done) begin
      chk("done_without_res", done, 0);
    end
  endtask

  task automatic sample_point();
    @(negedge ctrl_clk);
    monitor();
  endtask

  task automatic tick_edge();
    @(posedge ctrl_clk);
    #1;
    cyc++;
  endtask

  task automatic cycle();
    sample_point();
    tick_edge();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_w_ready"},    w_ready, 0);
    chk({tag, "_a_ready"},    a_ready, 0);
    chk({tag, "_res_valid"},  res_valid, 0);
    chk({tag, "_done"},       done, 0);
    chk({tag, "_mode"},       array_mode, 0);
    chk({tag, "_en_up"},      array_en_up, 0);
    chk({tag, "_en_left"},    array_en_left, 0);
    chk({tag, "_data_left"},  array_data_left, 0);
    chk({tag, "_data_up"},    array_data_up, 0);
    chk({tag, "_res_data"},   res_data, 0);
  endtask

  task automatic send_w(input logic [BW-1:0] d);
    bit ok;
    ok = 0;
    w_valid = 1'b1;
    w_data  = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      sample_point();
      if (w_ready) begin
        ok = 1;
        chk("beat_en_up", array_en_up, 4'hF);
        chk("beat_data_up", array_data_up, d);
        chk("beat_mode", array_mode, 1);
      end
      tick_edge();
    end
    w_valid = 1'b0;
    w_data  = '0;
    chk("w_accepted", ok, 1);
  endtask

  task automatic send_a(input logic [BW-1:0] d);
    bit ok;
    ok = 0;
    a_valid = 1'b1;
    a_data  = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      sample_point();
      if (a_ready) begin
        ok = 1;
        chk("stream_en_left", array_en_left, 4'hF);
        chk("stream_mode", array_mode, 0);
        chk("stream_data_up", array_data_up, 0);
      end
      tick_edge();
    end
    a_valid = 1'b0;
    a_data  = '0;
    chk("a_accepted", ok, 1);
  endtask

  // One job: optional weight gap (with an ignored start during it), optional
  // one-cycle bubble after column bubble_at, then wait for done.
  task automatic run_job(input bit keep, input logic [3:0] ncols, input int wgap,
                         input int bubble_at, input bit poke);
    bit got;
    for (int j = 0; j < int'(ncols); j++) begin
      exp_t e;
      e.data = vecs[j].exp_res;
      e.last = (j == int'(ncols) - 1);
      exp_q.push_back(e);
    end
    start      = 1'b1;
    cfg_ncols  = ncols;
    cfg_keep_w = keep;
    cycle();
    start      = 1'b0;
    cfg_ncols  = 4'd0;
    cfg_keep_w = ~keep;
    sample_point();
    chk("first_busy", busy, 1);
    chk("first_w_ready", w_ready, !keep);
    chk("first_mode", array_mode, !keep);
    tick_edge();
    if (!keep) begin
      for (int k = 0; k < 4; k++) begin
        send_w(beats[k]);
        if (k == 1) begin
          for (int g = 0; g < wgap; g++) begin
            if (poke && g == 0) begin
              start      = 1'b1;
              cfg_ncols  = 4'd1;
              cfg_keep_w = 1'b1;
            end
            sample_point();
            chk("gap_en_up", array_en_up, 0);
            chk("gap_mode", array_mode, 1);
            tick_edge();
            start = 1'b0;
          end
        end
      end
    end
    for (int j = 0; j < int'(ncols); j++) begin
      send_a(vecs[j].b_col);
      if (j == bubble_at) begin
        a_data = pack4(99, 99, 99, 99);
        cycle();
        a_data = '0;
        chk("bubble_row0_zero", array_data_left[DW-1:0], 0);
      end
    end
    got = 0;
    for (int t = 0; t < 60 && !got; t++) begin
      sample_point();
      if (done) got = 1;
      tick_edge();
    end
    chk("job_done_seen", got, 1);
    chk("idle_after_done", busy, 0);
    chk("results_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end

  initial begin
    vecs[0].b_col = pack4(1, 4, 7, 10);  vecs[0].exp_res = pack4(70, 158, 246, 334);
    vecs[1].b_col = pack4(2, 5, 8, 11);  vecs[1].exp_res = pack4(80, 184, 288, 392);
    vecs[2].b_col = pack4(3, 6, 9, 12);  vecs[2].exp_res = pack4(90, 210, 330, 450);
    beats[0] = pack4(4, 8, 12, 16);
    beats[1] = pack4(3, 7, 11, 15);
    beats[2] = pack4(2, 6, 10, 14);
    beats[3] = pack4(1, 5, 9, 13);

    ctrl_rst_n = 1'b1;
    start      = 1'b0;
    cfg_ncols  = 4'd0;
    cfg_keep_w = 1'b0;
    w_valid    = 1'b0;
    w_data     = '0;
    a_valid    = 1'b0;
    a_data     = '0;

    // Power-on reset.
    #3 ctrl_rst_n = 1'b0;
    #1 chk_reset_outs("rst");
    cycle();
    cycle();
    sample_point();
    ctrl_rst_n = 1'b1;
    tick_edge();

    // Zero-column start is ignored.
    start     = 1'b1;
    cfg_ncols = 4'd0;
    cycle();
    start = 1'b0;
    chk("ncols0_busy", busy, 0);
    chk("ncols0_w_ready", w_ready, 0);

    // Plain job, weight gap with start poked during LOAD, bubble job, weight reuse.
    run_job(1'b0, 4'd3, 0, -1, 1'b0);
    run_job(1'b0, 4'd3, 2, -1, 1'b1);
    run_job(1'b0, 4'd3, 0, 0, 1'b0);
    run_job(1'b1, 4'd1, 0, -1, 1'b0);

    // Reset in STREAM after one column: everything drops at once, nothing follows.
    start      = 1'b1;
    cfg_ncols  = 4'd3;
    cfg_keep_w = 1'b0;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 4; k++) send_w(beats[k]);
    send_a(vecs[0].b_col);
    chk("pre_abort_busy", busy, 1);
    #2 ctrl_rst_n = 1'b0;
    #1 chk_reset_outs("abort");
    tick_edge();
    sample_point();
    ctrl_rst_n = 1'b1;
    tick_edge();
    for (int t = 0; t < 20; t++) cycle();
    chk("post_abort_busy", busy, 0);
    chk("post_abort_res_valid", res_valid, 0);

    // Fresh full job after the aborted one.
    run_job(1'b0, 4'd3, 0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
